// File: rtl/morse_char_decode_pkg.sv
// Shared widths, ASCII constants and type definitions for the Morse character decoder.
package morse_char_decode_pkg;

  localparam int MORSE_LEN_W       = 3;
  localparam int MAX_MORSE_LEN     = 6;
  localparam int MORSE_LUT_MAX_LEN = 5;

  localparam logic [7:0] MORSE_ASCII_SPACE = 8'h20;
  localparam logic [7:0] MORSE_ASCII_ERR   = 8'h3F;

  localparam int LUT_KEY_W = MORSE_LEN_W + MAX_MORSE_LEN;

  typedef enum logic [1:0] {
    KIND_CHAR = 2'd0,
    KIND_WORD = 2'd1,
    KIND_BAD  = 2'd2
  } event_kind_e;

  typedef enum logic {
    ST_SPACED  = 1'b0,
    ST_IN_WORD = 1'b1
  } space_state_e;

  // LUT key: element count in the upper bits, masked pattern (bit 0 = first element) below.
  function automatic logic [LUT_KEY_W-1:0] lut_key(input int len, input int pattern);
    logic [31:0] l;
    logic [31:0] p;
    l = len;
    p = pattern;
    return {l[MORSE_LEN_W-1:0], p[MAX_MORSE_LEN-1:0]};
  endfunction

endpackage

// File: rtl/morse_char_decode_lut.sv
// Combinational Morse pattern to uppercase ASCII lookup for A-Z and 0-9.
module morse_lut
  import morse_char_decode_pkg::*;
(
  input  logic [MORSE_LEN_W-1:0]   len,
  input  logic [MAX_MORSE_LEN-1:0] dits_dahs,
  output logic [7:0]               ascii,
  output logic                     hit
);

  logic [MAX_MORSE_LEN-1:0] pat_masked;
  logic [LUT_KEY_W-1:0]     key;

  // Elements at or beyond len are don't-care, so clear them before matching.
  generate
    for (genvar gi = 0; gi < MAX_MORSE_LEN; gi++) begin : g_mask
      assign pat_masked[gi] = dits_dahs[gi] & (len > MORSE_LEN_W'(gi));
    end
  endgenerate

  assign key = {len, pat_masked};

  always_comb begin
    ascii = 8'h00;
    hit   = 1'b1;
    case (key)
      lut_key(2,  2): ascii = "A";
      lut_key(4,  1): ascii = "B";
      lut_key(4,  5): ascii = "C";
      lut_key(3,  1): ascii = "D";
      lut_key(1,  0): ascii = "E";
      lut_key(4,  4): ascii = "F";
      lut_key(3,  3): ascii = "G";
      lut_key(4,  0): ascii = "H";
      lut_key(2,  0): ascii = "I";
      lut_key(4, 14): ascii = "J";
      lut_key(3,  5): ascii = "K";
      lut_key(4,  2): ascii = "L";
      lut_key(2,  3): ascii = "M";
      lut_key(2,  1): ascii = "N";
      lut_key(3,  7): ascii = "O";
      lut_key(4,  6): ascii = "P";
      lut_key(4, 11): ascii = "Q";
      lut_key(3,  2): ascii = "R";
      lut_key(3,  0): ascii = "S";
      lut_key(1,  1): ascii = "T";
      lut_key(3,  4): ascii = "U";
      lut_key(4,  8): ascii = "V";
      lut_key(3,  6): ascii = "W";
      lut_key(4,  9): ascii = "X";
      lut_key(4, 13): ascii = "Y";
      lut_key(4,  3): ascii = "Z";
      lut_key(5, 31): ascii = "0";
      lut_key(5, 30): ascii = "1";
      lut_key(5, 28): ascii = "2";
      lut_key(5, 24): ascii = "3";
      lut_key(5, 16): ascii = "4";
      lut_key(5,  0): ascii = "5";
      lut_key(5,  1): ascii = "6";
      lut_key(5,  3): ascii = "7";
      lut_key(5,  7): ascii = "8";
      lut_key(5, 15): ascii = "9";
      default: begin
        ascii = 8'h00;
        hit   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/morse_char_decode.sv
// Morse character event decoder: LUT stage, word-space FSM and output FIFO.
// Optional MORSE_ERROR_CHAR_EN: BAD events push '?' instead of being dropped.
module morse_char_decode
  import morse_char_decode_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [MORSE_LEN_W-1:0]   in_len,
  input  logic [MAX_MORSE_LEN-1:0] in_dits_dahs,
  input  logic                     in_error,
  input  logic                     in_word_end,
  output logic [7:0]               out_char,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [AW:0]              level,
  output logic                     ovf,
  input  logic                     ovf_clr
);

  localparam logic [AW:0] FULL_LEVEL = (AW + 1)'(DEPTH);

  logic [7:0]   lut_ascii;
  logic         lut_hit;
  event_kind_e  kind_d;

  logic         st_valid_q, st_valid_d;
  event_kind_e  st_kind_q, st_kind_d;
  logic [7:0]   st_char_q, st_char_d;

  space_state_e state_q, state_d, state_tgt;
  logic         push_req, push_ok, pop;
  logic [7:0]   push_data;

  logic [7:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]  level_q, level_d;
  logic         ovf_q, ovf_d;

  morse_lut u_lut (
    .len       (in_len),
    .dits_dahs (in_dits_dahs),
    .ascii     (lut_ascii),
    .hit       (lut_hit)
  );

  always_comb begin
    if (in_word_end)                kind_d = KIND_WORD;
    else if (!in_error && lut_hit)  kind_d = KIND_CHAR;
    else                            kind_d = KIND_BAD;
  end

  assign st_valid_d = in_valid;
  assign st_kind_d  = in_valid ? kind_d : st_kind_q;
  assign st_char_d  = in_valid ? lut_ascii : st_char_q;

  // Space FSM: decides what (if anything) stage 2 pushes and where it would go.
  always_comb begin
    push_req  = 1'b0;
    push_data = 8'h00;
    state_tgt = state_q;
    if (st_valid_q) begin
      case (st_kind_q)
        KIND_CHAR: begin
          push_req  = 1'b1;
          push_data = st_char_q;
          state_tgt = ST_IN_WORD;
        end
        KIND_WORD: begin
          if (state_q == ST_IN_WORD) begin
            push_req  = 1'b1;
            push_data = MORSE_ASCII_SPACE;
            state_tgt = ST_SPACED;
          end
        end
        KIND_BAD: begin
`ifdef MORSE_ERROR_CHAR_EN
          push_req  = 1'b1;
          push_data = MORSE_ASCII_ERR;
          state_tgt = ST_IN_WORD;
`endif
        end
        default: ;
      endcase
    end
  end

  assign out_valid = (level_q != '0);
  assign pop       = out_valid & out_ready;
  assign push_ok   = push_req & ((level_q != FULL_LEVEL) | pop);
  // A dropped push leaves the FSM where it was.
  assign state_d   = push_ok ? state_tgt : state_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
    if (push_ok && !pop)      level_d = level_q + (AW + 1)'(1);
    else if (!push_ok && pop) level_d = level_q - (AW + 1)'(1);
  end

  // Set wins over clear when both happen in one cycle.
  assign ovf_d = (ovf_q & ~ovf_clr) | (push_req & ~push_ok);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_valid_q <= 1'b0;
      st_kind_q  <= KIND_CHAR;
      st_char_q  <= 8'h00;
      state_q    <= ST_SPACED;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      ovf_q      <= 1'b0;
    end else begin
      st_valid_q <= st_valid_d;
      st_kind_q  <= st_kind_d;
      st_char_q  <= st_char_d;
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      ovf_q      <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

  assign out_char = out_valid ? mem_q[rd_ptr_q] : 8'h00;
  assign level    = level_q;
  assign ovf      = ovf_q;

endmodule

// File: tb/tb_morse_char_decode.sv
// Directed self-checking bench for morse_char_decode (DEPTH = 8).
module tb_morse_char_decode;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [2:0] in_len;
  logic [5:0] in_dits_dahs;
  logic       in_error;
  logic       in_word_end;
  logic [7:0] out_char;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] level;
  logic       ovf;
  logic       ovf_clr;

  int n_vec = 0;
  int n_err = 0;

  // Nine hand-encoded characters: E T A M N I S O H
  logic [2:0] c_len [9] = '{3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd2, 3'd3, 3'd3, 3'd4};
  logic [5:0] c_pat [9] = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd1, 6'd0, 6'd0, 6'd7, 6'd0};
  logic [7:0] c_asc [9] = '{8'h45, 8'h54, 8'h41, 8'h4D, 8'h4E, 8'h49, 8'h53, 8'h4F, 8'h48};

  morse_char_decode #(.DEPTH(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_len       (in_len),
    .in_dits_dahs (in_dits_dahs),
    .in_error     (in_error),
    .in_word_end  (in_word_end),
    .out_char     (out_char),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .level        (level),
    .ovf          (ovf),
    .ovf_clr      (ovf_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic drive(input logic [2:0] l, input logic [5:0] p, input logic e, input logic w);
    @(negedge clk);
    in_valid = 1'b1; in_len = l; in_dits_dahs = p; in_error = e; in_word_end = w;
  endtask

  task automatic release_in();
    @(negedge clk);
    in_valid = 1'b0; in_len = '0; in_dits_dahs = '0; in_error = 1'b0; in_word_end = 1'b0;
  endtask

  // Event in, then wait until its push is visible.
  task automatic send(input logic [2:0] l, input logic [5:0] p, input logic e, input logic w);
    drive(l, p, e, w);
    release_in();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    n_vec++;
    if (out_valid !== 1'b0 || level !== 4'd0 || ovf !== 1'b0 || out_char !== 8'h00) begin
      n_err++;
      $display("FAIL reset_state: got valid=%b level=%0d ovf=%b char=%h, required 0/0/0/00",
               out_valid, level, ovf, out_char);
    end
    $display("reset: valid=%b level=%0d ovf=%b char=%h", out_valid, level, ovf, out_char);
  endtask

  task automatic test_char_a();
    drive(3'd2, 6'b000010, 1'b0, 1'b0);
    release_in();
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL a_latency1: got valid=%b, required 0 one cycle after in_valid", out_valid);
    end
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b1 || out_char !== 8'h41 || level !== 4'd1) begin
      n_err++;
      $display("FAIL a_out: got valid=%b char=%h level=%0d, required 1/41/1", out_valid, out_char, level);
    end
    $display("char_a: valid=%b char=%h level=%0d", out_valid, out_char, level);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_vec++;
    if (level !== 4'd0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL a_pop: got level=%0d valid=%b, required 0/0", level, out_valid);
    end
  endtask

  task automatic test_sequence();
    logic [7:0] exp_s [4] = '{8'h53, 8'h4F, 8'h20, 8'h43};
    do_reset();
    send(3'd0, 6'd0, 1'b0, 1'b1);
    @(negedge clk);
    n_vec++;
    if (level !== 4'd0) begin
      n_err++;
      $display("FAIL word_after_reset: got level=%0d, required 0", level);
    end
    send(3'd3, 6'b000000, 1'b0, 1'b0);
    send(3'd3, 6'b000111, 1'b0, 1'b0);
    send(3'd0, 6'd0, 1'b0, 1'b1);
    send(3'd0, 6'd0, 1'b0, 1'b1);
    send(3'd4, 6'b000101, 1'b0, 1'b0);
    n_vec++;
    if (level !== 4'd4) begin
      n_err++;
      $display("FAIL seq_level: got level=%0d, required 4", level);
    end
    for (int i = 0; i < 4; i++) begin
      n_vec++;
      if (out_valid !== 1'b1 || out_char !== exp_s[i]) begin
        n_err++;
        $display("FAIL seq_char%0d: got valid=%b char=%h, required 1/%h", i, out_valid, out_char, exp_s[i]);
      end
      $display("sequence[%0d]: char=%h expected=%h", i, out_char, exp_s[i]);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
  endtask

  task automatic test_digits();
    logic [7:0] exp_d [5] = '{8'h30, 8'h39, 8'h51, 8'h59, 8'h41};
    send(3'd5, 6'b011111, 1'b0, 1'b0);
    send(3'd5, 6'b001111, 1'b0, 1'b0);
    send(3'd4, 6'b001011, 1'b0, 1'b0);
    send(3'd4, 6'b001101, 1'b0, 1'b0);
    send(3'd2, 6'b111110, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if (out_valid !== 1'b1 || out_char !== exp_d[i]) begin
        n_err++;
        $display("FAIL digit_char%0d: got valid=%b char=%h, required 1/%h", i, out_valid, out_char, exp_d[i]);
      end
      $display("digits[%0d]: char=%h expected=%h", i, out_char, exp_d[i]);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
  endtask

  task automatic test_bad();
    do_reset();
    send(3'd3, 6'b000000, 1'b1, 1'b0);
    send(3'd5, 6'b001011, 1'b0, 1'b0);
    send(3'd0, 6'd0, 1'b0, 1'b1);
`ifdef MORSE_ERROR_CHAR_EN
    begin
      logic [7:0] exp_b [3] = '{8'h3F, 8'h3F, 8'h20};
      n_vec++;
      if (level !== 4'd3) begin
        n_err++;
        $display("FAIL bad_level: got level=%0d, required 3", level);
      end
      for (int i = 0; i < 3; i++) begin
        n_vec++;
        if (out_char !== exp_b[i]) begin
          n_err++;
          $display("FAIL bad_char%0d: got %h, required %h", i, out_char, exp_b[i]);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
      end
    end
`else
    n_vec++;
    if (level !== 4'd0 || out_valid !== 1'b0) begin
      n_err++;
      $display("FAIL bad_dropped: got level=%0d valid=%b, required 0/0", level, out_valid);
    end
`endif
    $display("bad: level=%0d after error, unmatched and word events", level);
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 9; i++) drive(c_len[i], c_pat[i], 1'b0, 1'b0);
    release_in();
    @(negedge clk);
    n_vec++;
    if (level !== 4'd8 || ovf !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_full: got level=%0d ovf=%b, required 8/1", level, ovf);
    end
    for (int i = 0; i < 8; i++) begin
      n_vec++;
      if (out_valid !== 1'b1 || out_char !== c_asc[i]) begin
        n_err++;
        $display("FAIL ovf_drain%0d: got valid=%b char=%h, required 1/%h", i, out_valid, out_char, c_asc[i]);
      end
      $display("overflow drain[%0d]: char=%h expected=%h", i, out_char, c_asc[i]);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
    n_vec++;
    if (level !== 4'd0 || out_valid !== 1'b0 || ovf !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_empty: got level=%0d valid=%b ovf=%b, required 0/0/1", level, out_valid, ovf);
    end
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    n_vec++;
    if (ovf !== 1'b0) begin
      n_err++;
      $display("FAIL ovf_clr: got ovf=%b, required 0", ovf);
    end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 8; i++) drive(c_len[i], c_pat[i], 1'b0, 1'b0);
    release_in();
    @(negedge clk);
    drive(c_len[8], c_pat[8], 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_vec++;
    if (level !== 4'd8 || ovf !== 1'b0 || out_char !== 8'h54) begin
      n_err++;
      $display("FAIL full_pushpop: got level=%0d ovf=%b char=%h, required 8/0/54", level, ovf, out_char);
    end
    $display("full push+pop: level=%0d ovf=%b head=%h", level, ovf, out_char);
    for (int i = 1; i < 9; i++) begin
      n_vec++;
      if (out_char !== c_asc[i]) begin
        n_err++;
        $display("FAIL full_drain%0d: got %h, required %h", i, out_char, c_asc[i]);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) drive(c_len[i], c_pat[i], 1'b0, 1'b0);
    release_in();
    @(negedge clk);
    n_vec++;
    if (level !== 4'd3) begin
      n_err++;
      $display("FAIL b2b_level: got level=%0d, required 3", level);
    end
    $display("back_to_back: level=%0d", level);
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (out_char !== c_asc[i]) begin
        n_err++;
        $display("FAIL b2b_char%0d: got %h, required %h", i, out_char, c_asc[i]);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 4; i++) drive(c_len[i], c_pat[i], 1'b0, 1'b0);
    release_in();
    @(negedge clk);
    n_vec++;
    if (level !== 4'd4) begin
      n_err++;
      $display("FAIL mid_prefill: got level=%0d, required 4", level);
    end
    drive(c_len[4], c_pat[4], 1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    n_vec++;
    if (level !== 4'd0 || out_valid !== 1'b0 || out_char !== 8'h00) begin
      n_err++;
      $display("FAIL mid_reset: got level=%0d valid=%b char=%h, required 0/0/00", level, out_valid, out_char);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_vec++;
    if (level !== 4'd0) begin
      n_err++;
      $display("FAIL mid_inflight: got level=%0d, required 0", level);
    end
    send(3'd0, 6'd0, 1'b0, 1'b1);
    @(negedge clk);
    n_vec++;
    if (level !== 4'd0) begin
      n_err++;
      $display("FAIL mid_spaced: got level=%0d, required 0", level);
    end
    $display("reset_mid: level=%0d valid=%b", level, out_valid);
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_len = '0; in_dits_dahs = '0; in_error = 1'b0; in_word_end = 1'b0;
    out_ready = 1'b0; ovf_clr = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst = 1'b0;
    test_char_a();
    test_sequence();
    test_digits();
    test_bad();
    test_overflow();
    test_full_push_pop();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
